// File: rtl/dbus_bridge_pkg.sv
// rtl/dbus_bridge_pkg.sv - shared bus width, FSM state encoding and address helper for dbus_bridge
package dbus_bridge_pkg;

  localparam int DBUS_W      = 64;
  localparam int DBUS_MASK_W = DBUS_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } dbus_state_e;

  // The bus only ever sees doubleword addresses; byte lanes travel in the mask.
  function automatic logic [DBUS_W-1:0] dword_align(input logic [DBUS_W-1:0] i_addr);
    return {i_addr[DBUS_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/dbus_bridge_timeout.sv
// rtl/dbus_bridge_timeout.sv - bus watchdog counter, compiled only when DBUS_TIMEOUT_EN is defined
`ifdef DBUS_TIMEOUT_EN
module dbus_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires in the last allowed REQ/RESP cycle so the FSM leaves on the following edge.
  assign o_expired = i_run && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - CPU data port to registered valid/ready SoC bus bridge
module dbus_bridge
  import dbus_bridge_pkg::*;
  #(parameter int TIMEOUT_CYCLES = 256)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_in,
  input  logic                   flush_in,
  input  logic                   data_read_in,
  input  logic                   data_write_in,
  input  logic [DBUS_MASK_W-1:0] data_write_mask_in,
  input  logic [DBUS_W-1:0]      data_address_in,
  input  logic [DBUS_W-1:0]      data_write_value_in,
  output logic [DBUS_W-1:0]      data_read_value_out,
  output logic                   stall_out,
  output logic                   fault_out,
  output logic                   bus_valid_out,
  input  logic                   bus_ready_in,
  output logic                   bus_write_out,
  output logic [DBUS_W-1:0]      bus_address_out,
  output logic [DBUS_W-1:0]      bus_write_value_out,
  output logic [DBUS_MASK_W-1:0] bus_write_mask_out,
  input  logic                   bus_resp_valid_in,
  input  logic [DBUS_W-1:0]      bus_read_value_in
);

  dbus_state_e            r_state;
  logic                   r_valid;
  logic                   r_write;
  logic [DBUS_W-1:0]      r_addr;
  logic [DBUS_W-1:0]      r_wdata;
  logic [DBUS_MASK_W-1:0] r_mask;
  logic [DBUS_W-1:0]      r_rdata;

  logic w_wr;
  logic w_req;
  logic w_issue;

  // A write with no enabled bytes is a no-op; write takes priority over read.
  assign w_wr    = data_write_in && (|data_write_mask_in);
  assign w_req   = (data_read_in || w_wr) && !flush_in;
  assign w_issue = (r_state == ST_IDLE) && w_req;

  assign stall_out = w_issue || (r_state == ST_REQ) || (r_state == ST_RESP);

`ifdef DBUS_TIMEOUT_EN
  logic r_fault;
  logic w_expired;

  dbus_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_issue),
    .i_run    ((r_state == ST_REQ) || (r_state == ST_RESP)),
    .o_expired(w_expired)
  );

  assign fault_out = r_fault;
`else
  assign fault_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
`ifdef DBUS_TIMEOUT_EN
      r_fault <= 1'b0;
`endif
    end else begin
`ifdef DBUS_TIMEOUT_EN
      r_fault <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= dword_align(data_address_in);
            r_write <= w_wr;
            r_mask  <= w_wr ? data_write_mask_in : '0;
            r_wdata <= w_wr ? data_write_value_in : '0;
            r_valid <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_ready_in) begin
            r_valid <= 1'b0;
            r_state <= r_write ? ST_DONE : ST_RESP;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (w_expired) begin
            r_fault <= 1'b1;
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_state <= ST_DONE;
          end
`endif
        end
        ST_RESP: begin
          if (bus_resp_valid_in) begin
            r_rdata <= bus_read_value_in;
            r_state <= ST_DONE;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (w_expired) begin
            r_fault <= 1'b1;
            r_rdata <= '0;
            r_state <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          // Holding here while the pipeline is stalled elsewhere keeps the request from reissuing.
          if (!stall_in) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign data_read_value_out = r_rdata;
  assign bus_valid_out       = r_valid;
  assign bus_write_out       = r_write;
  assign bus_address_out     = r_addr;
  assign bus_write_value_out = r_wdata;
  assign bus_write_mask_out  = r_mask;

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - scoreboard bench for dbus_bridge (timeout case built when DBUS_TIMEOUT_EN is defined)
module tb_dbus_bridge;

`ifdef DBUS_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 256;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in, flush_in, data_read_in, data_write_in;
  logic [7:0]  data_write_mask_in;
  logic [63:0] data_address_in, data_write_value_in, data_read_value_out;
  logic        stall_out, fault_out, bus_valid_out, bus_ready_in, bus_write_out;
  logic [63:0] bus_address_out, bus_write_value_out, bus_read_value_in;
  logic [7:0]  bus_write_mask_out;
  logic        bus_resp_valid_in;

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [7:0]  mask;
    logic [63:0] wdata;
  } req_t;

  req_t        q_req[$];
  logic [63:0] q_rd[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_acc    = 0;
  int          g_ready_dly = 0;
  int          g_resp_dly  = 0;
  logic [63:0] g_rdata = '0;

  always #5 clk = ~clk;

  dbus_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall_in            (stall_in),
    .flush_in            (flush_in),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_address_in     (data_address_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .stall_out           (stall_out),
    .fault_out           (fault_out),
    .bus_valid_out       (bus_valid_out),
    .bus_ready_in        (bus_ready_in),
    .bus_write_out       (bus_write_out),
    .bus_address_out     (bus_address_out),
    .bus_write_value_out (bus_write_value_out),
    .bus_write_mask_out  (bus_write_mask_out),
    .bus_resp_valid_in   (bus_resp_valid_in),
    .bus_read_value_in   (bus_read_value_in)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Bus slave plus request scoreboard: every valid cycle must match the head entry.
  initial begin : slave
    int   vcnt;
    int   rcnt;
    logic rd_pending;
    logic acc;
    vcnt = 0; rcnt = 0; rd_pending = 1'b0;
    bus_ready_in = 1'b0; bus_resp_valid_in = 1'b0; bus_read_value_in = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        vcnt = 0; rd_pending = 1'b0;
      end else begin
        acc = bus_valid_out && bus_ready_in;
        if (bus_valid_out) begin
          if (q_req.size() == 0) begin
            chk("req_unexpected", 64'd1, 64'd0);
          end else begin
            chk("req_addr",  bus_address_out, q_req[0].addr);
            chk("req_write", 64'(bus_write_out), 64'(q_req[0].wr));
            chk("req_mask",  64'(bus_write_mask_out), 64'(q_req[0].mask));
            if (q_req[0].wr) chk("req_wdata", bus_write_value_out, q_req[0].wdata);
            if (acc) void'(q_req.pop_front());
          end
        end
        if (acc) begin
          n_acc++;
          if (!bus_write_out) begin rd_pending = 1'b1; rcnt = 0; end
        end
        vcnt = (bus_valid_out && !acc) ? vcnt + 1 : 0;
      end
      @(posedge clk); #1;
      bus_ready_in      = bus_valid_out && (vcnt == g_ready_dly);
      bus_resp_valid_in = 1'b0;
      if (rd_pending) begin
        if (rcnt == g_resp_dly) begin
          bus_resp_valid_in = 1'b1;
          bus_read_value_in = g_rdata;
          rd_pending = 1'b0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with the request withdrawn.
  task automatic access(input logic rd, input logic wr, input logic [7:0] mask,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                        input int rdly, input int respdly, input int hold, input logic flush);
    logic wr_eff, issue;
    int   exp_stall, stalls, acc0;
    wr_eff    = wr && (mask != 8'h00);
    issue     = (rd || wr_eff) && !flush;
    exp_stall = !issue ? 0 : (wr_eff ? 2 + rdly : 3 + rdly + respdly);
    g_ready_dly = rdly; g_resp_dly = respdly; g_rdata = rdata;
    if (issue) begin
      q_req.push_back('{{addr[63:3], 3'b000}, wr_eff, wr_eff ? mask : 8'h00, wdata});
      if (!wr_eff) q_rd.push_back(rdata);
    end
    acc0 = n_acc;
    data_read_in = rd; data_write_in = wr; data_write_mask_in = mask;
    data_address_in = addr; data_write_value_in = wdata;
    flush_in = flush; stall_in = (hold > 0);
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall_out) break;
      stalls++;
    end
    chk("stall_cycles", 64'(stalls), 64'(exp_stall));
    if (issue && !wr_eff) begin
      if (q_rd.size() == 0) chk("rd_queue_empty", 64'd1, 64'd0);
      else chk("read_value", data_read_value_out, q_rd.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      chk("done_stall", 64'(stall_out), 64'd0);
      @(negedge clk);
    end
    stall_in = 1'b0;
    @(posedge clk); #1;
    data_read_in = 1'b0; data_write_in = 1'b0; flush_in = 1'b0;
    @(negedge clk);
    chk("no_reissue_valid", 64'(bus_valid_out), 64'd0);
    chk("bus_requests", 64'(n_acc - acc0), 64'(issue));
    @(posedge clk); #1;
  endtask

  initial begin : main
    reset = 1'b1;
    stall_in = 1'b0; flush_in = 1'b0; data_read_in = 1'b0; data_write_in = 1'b0;
    data_write_mask_in = '0; data_address_in = '0; data_write_value_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus_valid_out), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    chk("rst_fault", 64'(fault_out), 64'd0);
    chk("rst_rdata", data_read_value_out, 64'd0);
    chk("rst_addr",  bus_address_out, 64'd0);
    chk("rst_mask",  64'(bus_write_mask_out), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 8'h00, 64'h1000_0006, 64'h0, 64'hDEAD_BEEF_1234_5678, 0, 0, 0, 1'b0);
    access(1'b0, 1'b1, 8'h30, 64'h1000_0014, 64'h0000_A5A5_0000_0000, 64'h0, 4, 0, 0, 1'b0);
    access(1'b1, 1'b0, 8'h00, 64'h0000_0000_0000_0FF8, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 2, 3, 1'b0);
    access(1'b1, 1'b0, 8'h00, 64'h4000_0000, 64'h0, 64'h1111_2222_3333_4444, 0, 0, 0, 1'b1);
    access(1'b0, 1'b1, 8'h00, 64'h5000_0000, 64'hFFFF, 64'h0, 0, 0, 0, 1'b0);
    access(1'b1, 1'b1, 8'h01, 64'h6000_0001, 64'h0000_0000_0000_00EE, 64'h9999, 0, 0, 0, 1'b0);

    // Reset while waiting for the read response.
    g_ready_dly = 0; g_resp_dly = 1000;
    q_req.push_back('{64'h2000_0000, 1'b0, 8'h00, 64'h0});
    data_read_in = 1'b1; data_address_in = 64'h2000_0004;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; data_read_in = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(bus_valid_out), 64'd0);
    chk("rst_resp_stall", 64'(stall_out), 64'd0);
    chk("rst_resp_rdata", data_read_value_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    q_req.delete();
    @(posedge clk); #1;
    access(1'b1, 1'b0, 8'h00, 64'h2000_0010, 64'h0, 64'hCAFE_F00D_0000_0001, 0, 0, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      logic [63:0] a, w, r;
      logic        is_wr;
      a = {$urandom, $urandom}; w = {$urandom, $urandom}; r = {$urandom, $urandom};
      is_wr = 1'($urandom_range(0, 1));
      access(!is_wr, is_wr, 8'($urandom_range(1, 255)), a, w, r,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

`ifdef DBUS_TIMEOUT_EN
    begin : timeout_case
      int fault_cnt, fault_at;
      fault_cnt = 0; fault_at = -1;
      g_ready_dly = 1000;
      q_req.push_back('{64'h3000_0008, 1'b0, 8'h00, 64'h0});
      data_read_in = 1'b1; data_address_in = 64'h3000_000C; stall_in = 1'b1;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (fault_out) begin
          fault_cnt++;
          if (fault_at < 0) fault_at = k;
        end
      end
      chk("fault_pulses", 64'(fault_cnt), 64'd1);
      chk("fault_cycle", 64'(fault_at), 64'd9);
      chk("fault_rdata", data_read_value_out, 64'd0);
      chk("fault_stall", 64'(stall_out), 64'd0);
      q_req.delete();
      data_read_in = 1'b0; stall_in = 1'b0;
      @(posedge clk); #1;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
